// File: rtl/vga_pkg.sv
// ============================================================================
// Module   : vga_pkg
// Purpose  : Shared types, default VGA timing and helpers for the scan-out engine.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package vga_pkg;

    typedef enum logic [1:0] {
        SYNC   = 2'd0,
        BACK   = 2'd1,
        ACTIVE = 2'd2,
        FRONT  = 2'd3
    } vga_state_t;

    localparam int c_H_SYNC_DEFAULT   = 96;
    localparam int c_H_BACK_DEFAULT   = 48;
    localparam int c_H_ACTIVE_DEFAULT = 640;
    localparam int c_H_FRONT_DEFAULT  = 16;
    localparam int c_V_SYNC_DEFAULT   = 2;
    localparam int c_V_BACK_DEFAULT   = 33;
    localparam int c_V_ACTIVE_DEFAULT = 480;
    localparam int c_V_FRONT_DEFAULT  = 10;

    function automatic int words_per_line(input int h_active, input int bpp);
        return (h_active * bpp) / 32;
    endfunction

    function automatic vga_state_t next_state(input vga_state_t s);
        case (s)
            SYNC:    return BACK;
            BACK:    return ACTIVE;
            ACTIVE:  return FRONT;
            default: return SYNC;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/vga_word_fifo.sv
// ============================================================================
// Module   : vga_word_fifo
// Purpose  : Show-ahead synchronous 32-bit FIFO with flush, used for pixel prefetch.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module vga_word_fifo #(
    parameter int DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_flush,
    input  logic        i_push,
    input  logic [31:0] i_data,
    input  logic        i_pop,
    output logic [31:0] o_data,
    output logic        o_full,
    output logic        o_empty
);

    localparam int           c_AW      = $clog2(DEPTH);
    localparam logic [c_AW:0] c_PTR_ONE = {{c_AW{1'b0}}, 1'b1};

    logic [31:0]   r_mem [DEPTH];
    logic [c_AW:0] r_wr_ptr;
    logic [c_AW:0] r_rd_ptr;
    logic          w_do_push;
    logic          w_do_pop;

    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                     (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);
    assign o_data  = r_mem[r_rd_ptr[c_AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[c_AW-1:0]] <= i_data;
    end

endmodule

`default_nettype wire

// File: rtl/vga_scanout.sv
// ============================================================================
// Module   : vga_scanout
// Purpose  : VGA sync generator and packed-framebuffer scan-out from SRAM.
// Options  : VGA_PIXEL_DOUBLE_EN - show each pixel for 2 clocks and each line twice.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module vga_scanout
    import vga_pkg::*;
#(
    parameter int          H_SYNC     = c_H_SYNC_DEFAULT,
    parameter int          H_BACK     = c_H_BACK_DEFAULT,
    parameter int          H_ACTIVE   = c_H_ACTIVE_DEFAULT,
    parameter int          H_FRONT    = c_H_FRONT_DEFAULT,
    parameter int          V_SYNC     = c_V_SYNC_DEFAULT,
    parameter int          V_BACK     = c_V_BACK_DEFAULT,
    parameter int          V_ACTIVE   = c_V_ACTIVE_DEFAULT,
    parameter int          V_FRONT    = c_V_FRONT_DEFAULT,
    parameter int          BPP        = 1,
    parameter int          FIFO_DEPTH = 8,
    parameter logic [31:0] FB_BASE    = 32'h0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [31:0]     SRAM_data_in,
    input  logic            SRAM_busy,
    output logic            data_en,
    output logic [31:0]     word_address_dest,
    output logic [3:0]      byte_select,
    output logic            h_out,
    output logic            v_out,
    output logic [BPP-1:0]  pixel_data,
    output logic            pixel_valid,
    output logic [9:0]      h_count,
    output logic [9:0]      v_count,
    output vga_state_t      h_state,
    output vga_state_t      v_state,
    output logic            frame_start,
    output logic            underrun
);

    localparam logic [9:0] c_H_SYNC_LAST   = 10'(H_SYNC - 1);
    localparam logic [9:0] c_H_BACK_LAST   = 10'(H_BACK - 1);
    localparam logic [9:0] c_H_ACTIVE_LAST = 10'(H_ACTIVE - 1);
    localparam logic [9:0] c_H_FRONT_LAST  = 10'(H_FRONT - 1);
    localparam logic [9:0] c_V_SYNC_LAST   = 10'(V_SYNC - 1);
    localparam logic [9:0] c_V_BACK_LAST   = 10'(V_BACK - 1);
    localparam logic [9:0] c_V_ACTIVE_LAST = 10'(V_ACTIVE - 1);
    localparam logic [9:0] c_V_FRONT_LAST  = 10'(V_FRONT - 1);
    localparam int         c_BPP_LOG2      = $clog2(BPP);
    localparam logic [4:0] c_PIX_LAST      = 5'(32 / BPP - 1);
`ifdef VGA_PIXEL_DOUBLE_EN
    localparam logic [31:0] c_FRAME_WORDS  = 32'(V_ACTIVE * H_ACTIVE * BPP / 128);
    localparam logic [31:0] c_PASS_LAST    = 32'(words_per_line(H_ACTIVE / 2, BPP) - 1);
`else
    localparam logic [31:0] c_FRAME_WORDS  = 32'(V_ACTIVE * words_per_line(H_ACTIVE, BPP));
`endif

    localparam logic [0:0] c_FETCH_IDLE = 1'b0;
    localparam logic [0:0] c_FETCH_REQ  = 1'b1;

    function automatic logic [9:0] h_last(input vga_state_t s);
        case (s)
            SYNC:    return c_H_SYNC_LAST;
            BACK:    return c_H_BACK_LAST;
            ACTIVE:  return c_H_ACTIVE_LAST;
            default: return c_H_FRONT_LAST;
        endcase
    endfunction

    function automatic logic [9:0] v_last(input vga_state_t s);
        case (s)
            SYNC:    return c_V_SYNC_LAST;
            BACK:    return c_V_BACK_LAST;
            ACTIVE:  return c_V_ACTIVE_LAST;
            default: return c_V_FRONT_LAST;
        endcase
    endfunction

    logic [9:0]     r_h_count, r_v_count, w_h_count_nx, w_v_count_nx;
    vga_state_t     r_h_state, r_v_state, w_h_state_nx, w_v_state_nx;
    logic           w_h_last, w_v_last, w_line_end, w_frame_wrap;
    logic           r_h_out, r_v_out, r_frame_start;
    logic [0:0]     r_fetch_state, w_fetch_state_nx;
    logic           w_data_en, w_push, w_pop;
    logic [31:0]    r_addr, r_words_left;
    logic [31:0]    w_fifo_head;
    logic           w_fifo_full, w_fifo_empty;
    logic           w_active_nx, w_pix_step;
    logic [4:0]     r_pix_idx, w_bit_off;
    logic [BPP-1:0] w_pix, r_pixel_data;
    logic           r_pixel_valid, r_underrun;

    // ------------------------------------------------------------------ timing
    always_comb begin
        w_h_last     = (r_h_count == h_last(r_h_state));
        w_line_end   = w_h_last && (r_h_state == FRONT);
        w_v_last     = (r_v_count == v_last(r_v_state));
        w_frame_wrap = w_line_end && w_v_last && (r_v_state == FRONT);
        w_h_count_nx = w_h_last ? '0 : r_h_count + 10'd1;
        w_h_state_nx = w_h_last ? next_state(r_h_state) : r_h_state;
        w_v_count_nx = r_v_count;
        w_v_state_nx = r_v_state;
        if (w_line_end) begin
            if (w_v_last) begin
                w_v_count_nx = '0;
                w_v_state_nx = next_state(r_v_state);
            end else begin
                w_v_count_nx = r_v_count + 10'd1;
            end
        end
    end

    // Syncs and pulses are computed from next-state so they line up with the counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_h_count     <= '0;
            r_v_count     <= '0;
            r_h_state     <= SYNC;
            r_v_state     <= SYNC;
            r_h_out       <= 1'b1;
            r_v_out       <= 1'b1;
            r_frame_start <= 1'b0;
        end else begin
            r_h_count     <= w_h_count_nx;
            r_v_count     <= w_v_count_nx;
            r_h_state     <= w_h_state_nx;
            r_v_state     <= w_v_state_nx;
            r_h_out       <= (w_h_state_nx != SYNC);
            r_v_out       <= (w_v_state_nx != SYNC);
            r_frame_start <= w_frame_wrap;
        end
    end

    // ------------------------------------------------------------------- fetch
    always_ff @(posedge clk) begin
        if (rst) r_fetch_state <= c_FETCH_IDLE;
        else     r_fetch_state <= w_fetch_state_nx;
    end

    always_comb begin
        w_fetch_state_nx = r_fetch_state;
        case (r_fetch_state)
            c_FETCH_IDLE: if (!w_fifo_full && (r_words_left != '0)) w_fetch_state_nx = c_FETCH_REQ;
            c_FETCH_REQ:  if (!SRAM_busy) w_fetch_state_nx = c_FETCH_IDLE;
            default:      w_fetch_state_nx = c_FETCH_IDLE;
        endcase
        if (w_frame_wrap) w_fetch_state_nx = c_FETCH_IDLE;
    end

    always_comb begin
        w_data_en = (r_fetch_state == c_FETCH_REQ);
    end

    assign w_push = w_data_en && !SRAM_busy && !w_frame_wrap;

`ifdef VGA_PIXEL_DOUBLE_EN
    logic [31:0] r_line_base, r_line_word;
    logic        r_pass;
`endif

    always_ff @(posedge clk) begin
        if (rst || w_frame_wrap) begin
            r_addr       <= FB_BASE;
            r_words_left <= c_FRAME_WORDS;
`ifdef VGA_PIXEL_DOUBLE_EN
            r_line_base  <= FB_BASE;
            r_line_word  <= '0;
            r_pass       <= 1'b0;
`endif
        end else if (w_push) begin
`ifdef VGA_PIXEL_DOUBLE_EN
            // First pass of a line rewinds for the repeat; second pass moves on.
            if (r_line_word == c_PASS_LAST) begin
                r_line_word <= '0;
                r_pass      <= !r_pass;
                if (!r_pass) begin
                    r_addr <= r_line_base;
                end else begin
                    r_addr      <= r_addr + 32'd1;
                    r_line_base <= r_addr + 32'd1;
                end
            end else begin
                r_line_word <= r_line_word + 32'd1;
                r_addr      <= r_addr + 32'd1;
            end
            if (r_pass) r_words_left <= r_words_left - 32'd1;
`else
            r_addr       <= r_addr + 32'd1;
            r_words_left <= r_words_left - 32'd1;
`endif
        end
    end

    vga_word_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_flush (w_frame_wrap),
        .i_push  (w_push),
        .i_data  (SRAM_data_in),
        .i_pop   (w_pop),
        .o_data  (w_fifo_head),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    // ------------------------------------------------------------------- pixel
    assign w_active_nx = (w_h_state_nx == ACTIVE) && (w_v_state_nx == ACTIVE);
    assign w_bit_off   = r_pix_idx << c_BPP_LOG2;
    assign w_pix       = w_fifo_head[w_bit_off +: BPP];

`ifdef VGA_PIXEL_DOUBLE_EN
    logic r_dbl_phase;

    always_ff @(posedge clk) begin
        if (rst || w_frame_wrap) r_dbl_phase <= 1'b0;
        else if (w_active_nx)    r_dbl_phase <= !r_dbl_phase;
    end

    assign w_pix_step = w_active_nx && r_dbl_phase;
`else
    assign w_pix_step = w_active_nx;
`endif

    // An empty FIFO still advances the pointer; alignment is restored at frame wrap.
    assign w_pop = w_pix_step && !w_fifo_empty && (r_pix_idx == c_PIX_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pix_idx     <= '0;
            r_pixel_data  <= '0;
            r_pixel_valid <= 1'b0;
            r_underrun    <= 1'b0;
        end else begin
            r_pixel_valid <= w_active_nx;
            r_pixel_data  <= (w_active_nx && !w_fifo_empty) ? w_pix : '0;
            if (w_frame_wrap)    r_pix_idx <= '0;
            else if (w_pix_step) r_pix_idx <= (r_pix_idx == c_PIX_LAST) ? '0 : r_pix_idx + 5'd1;
            if (w_frame_wrap)                     r_underrun <= 1'b0;
            else if (w_active_nx && w_fifo_empty) r_underrun <= 1'b1;
        end
    end

    // ----------------------------------------------------------------- outputs
    assign data_en           = w_data_en;
    assign word_address_dest = w_data_en ? r_addr : '0;
    assign byte_select       = 4'hF;
    assign h_out             = r_h_out;
    assign v_out             = r_v_out;
    assign pixel_data        = r_pixel_data;
    assign pixel_valid       = r_pixel_valid;
    assign h_count           = r_h_count;
    assign v_count           = r_v_count;
    assign h_state           = r_h_state;
    assign v_state           = r_v_state;
    assign frame_start       = r_frame_start;
    assign underrun          = r_underrun;

endmodule

`default_nettype wire
